// File: rtl/miner_pkg.sv
// Shared constants for the miner serial link: frame bytes, frame length,
// transmit FSM encoding and the frame byte selector.
package miner_pkg;

  localparam logic [7:0] SOF_BYTE_DEF    = 8'hA5;
  localparam logic [7:0] TYPE_RESULT_DEF = 8'h02;
  localparam int unsigned FRAME_LEN      = 7;
  localparam logic [2:0] FRAME_LAST_IDX  = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  // Byte idx of a result frame: SOF, TYPE, four data bytes LSB first, CHK.
  // CHK covers TYPE and the data bytes only; SOF is left out so a receiver
  // can resynchronise on SOF without disturbing its checksum.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [7:0]  sof,
    input logic [7:0]  typ,
    input logic [31:0] data
  );
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = sof;
      3'd1:    b = typ;
      3'd2:    b = data[7:0];
      3'd3:    b = data[15:8];
      3'd4:    b = data[23:16];
      3'd5:    b = data[31:24];
      3'd6:    b = typ ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// A write into a full FIFO is accepted when a pop happens in the same cycle.
module result_fifo
  import miner_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_acc, rd_acc;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // Accept logic and next pointers; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    rd_acc   = rd_en && !empty;
    wr_acc   = wr_en && (!full || rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/result_tx_framer.sv
// Buffers nonce results and serialises each one as a 7-byte frame onto the
// byte-wide transmit handshake of avr_interface.
module result_tx_framer
  import miner_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SOF_BYTE    = SOF_BYTE_DEF,
  parameter logic [7:0] TYPE_RESULT = TYPE_RESULT_DEF,
  localparam int        LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          new_result,
  input  logic [31:0]   result_data,
  output logic [7:0]    tx_data,
  output logic          new_tx_data,
  input  logic          tx_busy,
  output logic          busy,
  output logic [LW-1:0] fifo_level,
  output logic [7:0]    drop_count
);

  tx_state_e   state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic        pop;
  logic        drop;

  logic [31:0]   fifo_rd_data;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_count;

  result_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (new_result),
    .wr_data (result_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Transmit FSM. tx_data is preloaded when SEND is entered so the byte is
  // already registered on the cycle the strobe goes out; the strobe itself
  // follows tx_busy directly so the SOF lands two cycles after new_result.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    shadow_d    = shadow_q;
    tx_data_d   = tx_data_q;
    pop         = 1'b0;
    new_tx_data = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shadow_d   = fifo_rd_data;
          byte_idx_d = 3'd0;
          tx_data_d  = SOF_BYTE;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        // One dead cycle lets a late-rising tx_busy be seen before the next byte.
        if (byte_idx_q == FRAME_LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          byte_idx_d = byte_idx_q + 3'd1;
          tx_data_d  = frame_byte(byte_idx_q + 3'd1, SOF_BYTE, TYPE_RESULT, shadow_q);
          state_d    = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Drop accounting: a write is lost only when full and nothing pops this cycle.
  always_comb begin
    drop         = new_result && fifo_full && !pop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= 3'd0;
      shadow_q     <= 32'd0;
      tx_data_q    <= 8'd0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      shadow_q     <= shadow_d;
      tx_data_q    <= tx_data_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign fifo_level = fifo_count;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_result_tx_framer.sv
// Directed bench for result_tx_framer with a byte scoreboard.
module tb_result_tx_framer;

  logic        clk;
  logic        rst_n;
  logic        new_result;
  logic [31:0] result_data;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int strobe_cnt = 0;
  int byte_pos   = 0;
  bit prev_strobe = 0;
  bit chk_seen    = 0;

  result_tx_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .new_result  (new_result),
    .result_data (result_data),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_frame(input logic [31:0] d);
    logic [7:0] chk;
    chk = 8'h02 ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(chk);
  endfunction

  // One-cycle new_result strobe; caller decides whether a frame is expected.
  task automatic strobe_result(input logic [31:0] d, input bit accepted);
    new_result  = 1'b1;
    result_data = d;
    if (accepted) push_frame(d);
    step();
    new_result = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic wait_strobe(input string tag, input int max_cycles);
    int prev, n;
    prev = strobe_cnt;
    n    = 0;
    while (strobe_cnt == prev && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, (strobe_cnt != prev), 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_strobe"}, new_tx_data, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_level"}, fifo_level, 3'd0);
    check({tag, "_drops"}, drop_count, 8'h00);
  endtask

  // Scoreboard monitor: every strobe pops one expected byte; strobes never adjacent.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst_n) begin
      byte_pos    = 0;
      prev_strobe = 0;
    end else begin
      if (new_tx_data) begin
        check("strobe_spacing", prev_strobe, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", new_tx_data, 1'b0);
        end else begin
          exp_b = exp_q.pop_front();
          check($sformatf("frame_byte%0d", byte_pos), tx_data, exp_b);
        end
        $display("tx byte %0d = %02h", byte_pos, tx_data);
        strobe_cnt++;
        if (byte_pos == 6) begin
          byte_pos = 0;
          chk_seen = 1;
        end else begin
          byte_pos++;
        end
      end
      prev_strobe = new_tx_data;
    end
  end

  initial begin
    int cnt_before;
    rst_n       = 1'b0;
    new_result  = 1'b0;
    result_data = 32'd0;
    tx_busy     = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    step();
    check_reset_outputs("after_reset");

    // Single result, idle transmitter: literal bytes and 2-cycle latency.
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h78);
    exp_q.push_back(8'h56); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'h0A);
    new_result  = 1'b1;
    result_data = 32'h12345678;
    @(negedge clk);
    check("lat_n_strobe", new_tx_data, 1'b0);
    step();
    new_result = 1'b0;
    @(negedge clk);
    check("lat_n1_strobe", new_tx_data, 1'b0);
    check("lat_n1_level", fifo_level, 3'd1);
    check("lat_n1_busy", busy, 1'b1);
    @(negedge clk);
    check("lat_n2_strobe", new_tx_data, 1'b1);
    check("lat_n2_sof", tx_data, 8'hA5);
    check("lat_n2_level", fifo_level, 3'd0);
    drain("single", 200);
    $display("single frame 12345678 done");

    // Transmitter busy for 100 cycles after each accepted byte.
    strobe_result(32'h89ABCDEF, 1'b1);
    for (int b = 0; b < 7; b++) begin
      wait_strobe($sformatf("slow_wait%0d", b), 50);
      tx_busy    = 1'b1;
      cnt_before = strobe_cnt;
      repeat (100) step();
      check($sformatf("slow_hold%0d", b), strobe_cnt, cnt_before);
      tx_busy = 1'b0;
    end
    drain("slow", 50);
    $display("slow frame 89ABCDEF done");

    // Five back-to-back results with a stalled transmitter.
    tx_busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      strobe_result(32'(k), 1'b1);
      check($sformatf("five_level%0d", k), fifo_level, (k == 1) ? 3'd1 : 3'(k - 1));
    end
    check("five_drops", drop_count, 8'h00);
    tx_busy = 1'b0;
    drain("five", 1000);
    $display("five frames done");

    // Overflow: sixth result dropped, then saturate the drop counter.
    tx_busy = 1'b1;
    for (int k = 1; k <= 5; k++) strobe_result(32'(k), 1'b1);
    strobe_result(32'h00000006, 1'b0);
    check("ovf_drop1", drop_count, 8'h01);
    check("ovf_level", fifo_level, 3'd4);
    new_result  = 1'b1;
    result_data = 32'h00000007;
    repeat (300) step();
    new_result = 1'b0;
    check("ovf_saturate", drop_count, 8'hFF);
    strobe_result(32'h00000008, 1'b0);
    check("ovf_sat_hold", drop_count, 8'hFF);
    tx_busy = 1'b0;
    drain("ovf", 1000);
    check("ovf_final_drops", drop_count, 8'hFF);
    $display("overflow sequence done");

    // Full FIFO, new_result on the IDLE pop cycle is accepted.
    do_reset();
    check_reset_outputs("reset2");
    tx_busy = 1'b1;
    for (int k = 0; k < 5; k++) strobe_result(32'hA0A0A0A0 + 32'(k), 1'b1);
    check("coin_full_level", fifo_level, 3'd4);
    chk_seen = 0;
    tx_busy  = 1'b0;
    begin
      int n;
      n = 0;
      while (!chk_seen && n < 200) begin
        step();
        n++;
      end
      check("coin_chk_seen", chk_seen, 1'b1);
    end
    step();
    check("coin_pre_level", fifo_level, 3'd4);
    strobe_result(32'h5EED5EED, 1'b1);
    check("coin_level", fifo_level, 3'd4);
    check("coin_drops", drop_count, 8'h00);
    drain("coin", 1000);
    $display("coincident pop/write done");

    // Reset after the third byte of a frame abandons it.
    cnt_before = strobe_cnt;
    strobe_result(32'hCAFEBABE, 1'b1);
    for (int b = 0; b < 3; b++) wait_strobe($sformatf("rst_wait%0d", b), 50);
    check("rst_three_bytes", strobe_cnt - cnt_before, 3);
    do_reset();
    check_reset_outputs("midframe_reset");
    cnt_before = strobe_cnt;
    repeat (20) step();
    check("rst_quiet", strobe_cnt, cnt_before);
    strobe_result(32'h0BADF00D, 1'b1);
    drain("rst_fresh", 200);
    $display("mid-frame reset done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
